cuenta_supervisor: RTL and testbench

CUENTA_SUPERVISOR -- requirements
Module: cuenta_supervisor

---
 rtl/cuenta_supervisor.sv | 184 ++++++++++++++++++
 tb/tb_cuenta_supervisor.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/cuenta_supervisor.sv
// cuenta_supervisor
// Supervises an external 4-bit up/down counter. On start it forces the
// counter to zero, then drives it up to 15 and back down to 0 repeatedly.
// Every valid sample is checked against the value expected from the
// previous sample, and mismatches are counted. The run ends after
// MAX_SWEEPS direction reversals.
//
// Ports:
//   clk        single clock, rising edge
//   reset      asynchronous, active-low reset
//   start      one-cycle request to begin a run (honoured only in IDLE)
//   cnt_in     current counter value
//   cnt_valid  cnt_in carries a new sample this cycle
//   updown     direction to the counter (1 = up, 0 = down)
//   load       one-cycle pulse asking the counter to load load_val
//   load_val   value to load (always zero)
//   sweeps     reversals completed in the current or last run
//   err        sticky, at least one mismatch this run
//   err_cnt    mismatch count, saturating at 255
//   busy       high while a run is active (LOAD, UP, DOWN)
//   done       one-cycle pulse on run completion
module cuenta_supervisor #(
    parameter int unsigned MAX_SWEEPS = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [3:0] cnt_in,
    input  logic       cnt_valid,
    output logic       updown,
    output logic       load,
    output logic [3:0] load_val,
    output logic [8:0] sweeps,
    output logic       err,
    output logic [7:0] err_cnt,
    output logic       busy,
    output logic       done
);

    localparam logic [8:0] SWEEP_LIMIT = MAX_SWEEPS[8:0];

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        UP,
        DOWN,
        FIN
    } state_t;

    state_t     state, state_nx;
    logic [3:0] prev, prev_nx;
    logic       updown_nx, load_nx, err_nx, busy_nx, done_nx;
    logic [8:0] sweeps_nx;
    logic [7:0] err_cnt_nx;

    logic [3:0] expected;
    logic       mismatch;
    logic       reverse;
    logic [8:0] sweeps_inc;
    logic       last_sweep;

    assign load_val = 4'd0;

    // Sample checking. A plain +1/-1 compare would accept a 15->0 wrap in
    // UP (or 0->15 in DOWN), so wraps are flagged explicitly. Reversal
    // points are decided independently of the mismatch so both can apply
    // on the same sample.
    always_comb begin
        expected   = (state == DOWN) ? (prev - 4'd1) : (prev + 4'd1);
        mismatch   = 1'b0;
        reverse    = 1'b0;
        if (state == UP) begin
            mismatch = (cnt_in != expected) || (prev == 4'd15 && cnt_in == 4'd0);
            reverse  = (cnt_in == 4'd15);
        end else if (state == DOWN) begin
            mismatch = (cnt_in != expected) || (prev == 4'd0 && cnt_in == 4'd15);
            reverse  = (cnt_in == 4'd0);
        end
        sweeps_inc = sweeps + 9'd1;
        last_sweep = (sweeps_inc == SWEEP_LIMIT);
    end

    // Next-state and next-output logic. Outputs are computed for the state
    // being entered so that, once registered, load is high exactly while in
    // LOAD and done exactly while in FIN.
    always_comb begin
        state_nx   = state;
        prev_nx    = prev;
        updown_nx  = updown;
        load_nx    = 1'b0;
        sweeps_nx  = sweeps;
        err_nx     = err;
        err_cnt_nx = err_cnt;
        busy_nx    = busy;
        done_nx    = 1'b0;

        case (state)
            IDLE: begin
                updown_nx = 1'b1;
                busy_nx   = 1'b0;
                if (start) begin
                    state_nx   = LOAD;
                    sweeps_nx  = 9'd0;
                    err_nx     = 1'b0;
                    err_cnt_nx = 8'd0;
                    prev_nx    = 4'd0;
                    load_nx    = 1'b1;
                    busy_nx    = 1'b1;
                end
            end

            LOAD: begin
                state_nx  = UP;
                updown_nx = 1'b1;
                busy_nx   = 1'b1;
            end

            UP, DOWN: begin
                if (cnt_valid) begin
                    prev_nx = cnt_in;
                    if (mismatch) begin
                        err_nx = 1'b1;
                        if (err_cnt != 8'hFF) begin
                            err_cnt_nx = err_cnt + 8'd1;
                        end
                    end
                    if (reverse) begin
                        sweeps_nx = sweeps_inc;
                        if (last_sweep) begin
                            state_nx  = FIN;
                            busy_nx   = 1'b0;
                            done_nx   = 1'b1;
                            updown_nx = 1'b1;
                        end else if (state == UP) begin
                            state_nx  = DOWN;
                            updown_nx = 1'b0;
                        end else begin
                            state_nx  = UP;
                            updown_nx = 1'b1;
                        end
                    end
                end
            end

            FIN: begin
                state_nx  = IDLE;
                busy_nx   = 1'b0;
                updown_nx = 1'b1;
            end

            default: begin
                state_nx  = IDLE;
                busy_nx   = 1'b0;
                updown_nx = 1'b1;
            end
        endcase
    end

    // State and output registers, cleared asynchronously while reset is low.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            prev    <= 4'd0;
            updown  <= 1'b1;
            load    <= 1'b0;
            sweeps  <= 9'd0;
            err     <= 1'b0;
            err_cnt <= 8'd0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_nx;
            prev    <= prev_nx;
            updown  <= updown_nx;
            load    <= load_nx;
            sweeps  <= sweeps_nx;
            err     <= err_nx;
            err_cnt <= err_cnt_nx;
            busy    <= busy_nx;
            done    <= done_nx;
        end
    end

endmodule

// File: tb/tb_cuenta_supervisor.sv
// tb_cuenta_supervisor
// Directed bench for cuenta_supervisor with the default MAX_SWEEPS of 5.
// Inputs change on the falling edge; outputs are checked on the falling
// edge after the rising edge that consumed them.
module tb_cuenta_supervisor;

    logic       clk;
    logic       reset;
    logic       start;
    logic [3:0] cnt_in;
    logic       cnt_valid;
    logic       updown;
    logic       load;
    logic [3:0] load_val;
    logic [8:0] sweeps;
    logic       err;
    logic [7:0] err_cnt;
    logic       busy;
    logic       done;

    int total;
    int bad;
    int done_pulses;

    cuenta_supervisor dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .cnt_in    (cnt_in),
        .cnt_valid (cnt_valid),
        .updown    (updown),
        .load      (load),
        .load_val  (load_val),
        .sweeps    (sweeps),
        .err       (err),
        .err_cnt   (err_cnt),
        .busy      (busy),
        .done      (done)
    );

    // 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Count cycles with done high, sampled away from the rising edge
    always @(negedge clk) begin
        if (done === 1'b1) done_pulses++;
    end

    // Single comparison point for the whole bench
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d want %0d", tag, observed, expected);
        end
    endtask

    // Present one valid counter sample for one rising edge; returns on the
    // falling edge after it was consumed
    task automatic applyStimulus(input logic [3:0] v);
        @(negedge clk);
        cnt_valid = 1'b1;
        cnt_in    = v;
        @(negedge clk);
        cnt_valid = 1'b0;
    endtask

    // Pulse start and check the LOAD cycle, then step into UP
    task automatic startRun();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checkOutput("load_pulse", load, 1'b1);
        checkOutput("load_busy", busy, 1'b1);
        checkOutput("load_sweeps", sweeps, 9'd0);
        checkOutput("load_err_cnt", err_cnt, 8'd0);
        checkOutput("load_updown", updown, 1'b1);
        @(negedge clk);
        checkOutput("load_one_cycle", load, 1'b0);
    endtask

    initial begin
        total       = 0;
        bad         = 0;
        done_pulses = 0;
        reset       = 1'b0;
        start       = 1'b0;
        cnt_in      = 4'd0;
        cnt_valid   = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        checkOutput("rst_updown", updown, 1'b1);
        checkOutput("rst_load", load, 1'b0);
        checkOutput("rst_load_val", load_val, 4'd0);
        checkOutput("rst_sweeps", sweeps, 9'd0);
        checkOutput("rst_err", err, 1'b0);
        checkOutput("rst_err_cnt", err_cnt, 8'd0);
        checkOutput("rst_busy", busy, 1'b0);
        checkOutput("rst_done", done, 1'b0);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("idle_busy", busy, 1'b0);

        // Clean run with a 10-cycle gap and ignored start pulses
        startRun();
        for (int v = 1; v <= 15; v++) applyStimulus(4'(v));
        checkOutput("clean_sw1", sweeps, 9'd1);
        checkOutput("clean_dir_down", updown, 1'b0);
        for (int v = 14; v >= 0; v--) applyStimulus(4'(v));
        checkOutput("clean_sw2", sweeps, 9'd2);
        checkOutput("clean_dir_up", updown, 1'b1);
        for (int v = 1; v <= 7; v++) applyStimulus(4'(v));
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            start  = i[0];
            cnt_in = 4'(i + 3);
        end
        @(negedge clk);
        start = 1'b0;
        checkOutput("gap_sweeps", sweeps, 9'd2);
        checkOutput("gap_updown", updown, 1'b1);
        checkOutput("gap_busy", busy, 1'b1);
        checkOutput("gap_load", load, 1'b0);
        checkOutput("gap_err_cnt", err_cnt, 8'd0);
        for (int v = 8; v <= 15; v++) applyStimulus(4'(v));
        checkOutput("clean_sw3", sweeps, 9'd3);
        for (int v = 14; v >= 0; v--) applyStimulus(4'(v));
        checkOutput("clean_sw4", sweeps, 9'd4);
        for (int v = 1; v <= 14; v++) applyStimulus(4'(v));
        checkOutput("clean_pre_fin_done", done, 1'b0);
        applyStimulus(4'd15);
        checkOutput("fin_done", done, 1'b1);
        checkOutput("fin_busy", busy, 1'b0);
        checkOutput("fin_sweeps", sweeps, 9'd5);
        checkOutput("fin_err", err, 1'b0);
        checkOutput("fin_err_cnt", err_cnt, 8'd0);
        // start during FIN must be ignored
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checkOutput("fin_start_busy", busy, 1'b0);
        checkOutput("fin_start_load", load, 1'b0);
        checkOutput("done_one_cycle", done, 1'b0);
        @(negedge clk);
        checkOutput("idle_after_fin_busy", busy, 1'b0);
        checkOutput("idle_updown", updown, 1'b1);
        checkOutput("idle_hold_sweeps", sweeps, 9'd5);
        checkOutput("done_pulses_run1", done_pulses, 1);

        // Skipped value, wrap, combined mismatch+reversal, then reset mid-run
        startRun();
        for (int v = 1; v <= 4; v++) applyStimulus(4'(v));
        checkOutput("skip_pre_err", err, 1'b0);
        applyStimulus(4'd6);
        checkOutput("skip_err", err, 1'b1);
        checkOutput("skip_err_cnt", err_cnt, 8'd1);
        applyStimulus(4'd7);
        checkOutput("skip_resync", err_cnt, 8'd1);
        for (int v = 8; v <= 14; v++) applyStimulus(4'(v));
        applyStimulus(4'd0);
        checkOutput("wrap_err_cnt", err_cnt, 8'd2);
        checkOutput("wrap_updown", updown, 1'b1);
        checkOutput("wrap_sweeps", sweeps, 9'd0);
        for (int v = 1; v <= 12; v++) applyStimulus(4'(v));
        applyStimulus(4'd15);
        checkOutput("combo_err_cnt", err_cnt, 8'd3);
        checkOutput("combo_sweeps", sweeps, 9'd1);
        checkOutput("combo_updown", updown, 1'b0);
        for (int v = 14; v >= 0; v--) applyStimulus(4'(v));
        applyStimulus(4'd1);
        applyStimulus(4'd2);
        checkOutput("pre_rst_sweeps", sweeps, 9'd2);
        checkOutput("pre_rst_busy", busy, 1'b1);
        #2 reset = 1'b0;
        #1;
        checkOutput("mid_rst_sweeps", sweeps, 9'd0);
        checkOutput("mid_rst_err", err, 1'b0);
        checkOutput("mid_rst_err_cnt", err_cnt, 8'd0);
        checkOutput("mid_rst_busy", busy, 1'b0);
        checkOutput("mid_rst_updown", updown, 1'b1);
        checkOutput("mid_rst_done", done, 1'b0);
        repeat (2) @(negedge clk);

        // Start on the reset release edge, then saturate err_cnt
        reset = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checkOutput("rel_start_load", load, 1'b1);
        checkOutput("rel_start_busy", busy, 1'b1);
        @(negedge clk);
        for (int i = 0; i < 255; i++) applyStimulus(4'd5);
        checkOutput("sat_reach", err_cnt, 8'd255);
        for (int i = 0; i < 45; i++) applyStimulus(4'd5);
        checkOutput("sat_hold", err_cnt, 8'd255);
        checkOutput("sat_err", err, 1'b1);
        checkOutput("sat_sweeps", sweeps, 9'd0);
        checkOutput("sat_busy", busy, 1'b1);
        checkOutput("done_pulses_total", done_pulses, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
